hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl_if.sv | 38 +++
 rtl/hazard_stall_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller bundle: hazard inputs from the ID/EX/MEM stages,
// stage-enable/flush controls and performance counters back to the pipeline.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             ID_UseRt;
  logic             ID_Jump;
  logic [4:0]       EX_rt;
  logic             EX_MemRead;
  logic             EX_BranchTaken;
  logic             MEM_MemAccess;
  logic             mem_ready;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             EX_MEM_Hold;
  logic             MEM_WB_Bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_timeout;

  modport master (
    output ID_rs, ID_rt, ID_UseRt, ID_Jump, EX_rt, EX_MemRead, EX_BranchTaken,
           MEM_MemAccess, mem_ready,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Hold,
           MEM_WB_Bubble, stall_cnt, flush_cnt, mem_timeout
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UseRt, ID_Jump, EX_rt, EX_MemRead, EX_BranchTaken,
           MEM_MemAccess, mem_ready,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Hold,
           MEM_WB_Bubble, stall_cnt, flush_cnt, mem_timeout
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: memory-wait stall FSM with timeout, load-use bubble,
// branch/jump flushes, and stall/flush performance counters.
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  hz
);

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_t            state_r, state_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_nxt_s;
  logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
  logic              mem_timeout_r;
  logic              mem_stall_s, load_use_s, flush_evt_s;
  logic              pc_write_s, if_id_write_s, if_id_flush_s;
  logic              id_ex_flush_s, ex_mem_hold_s, mem_wb_bubble_s;

  // Hazard detection: memory stall depends on state, load-use on the EX/ID registers
  always_comb begin
    mem_stall_s = 1'b0;
    load_use_s  = 1'b0;
    if (state_r == MEM_WAIT) begin
      mem_stall_s = !hz.mem_ready;
    end else begin
      mem_stall_s = hz.MEM_MemAccess && !hz.mem_ready;
    end
    if (hz.EX_MemRead && (hz.EX_rt != 5'd0)) begin
      load_use_s = (hz.EX_rt == hz.ID_rs) || (hz.ID_UseRt && (hz.EX_rt == hz.ID_rt));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Priority resolution of the pipeline controls; a released MEM_WAIT falls through to RUN rules
  always_comb begin
    pc_write_s      = 1'b1;
    if_id_write_s   = 1'b1;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    ex_mem_hold_s   = 1'b0;
    mem_wb_bubble_s = 1'b0;
    if (mem_stall_s) begin
      pc_write_s      = 1'b0;
      if_id_write_s   = 1'b0;
      ex_mem_hold_s   = 1'b1;
      mem_wb_bubble_s = 1'b1;
    end else if (hz.EX_BranchTaken) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if (load_use_s) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      id_ex_flush_s = 1'b1;
    end else if (hz.ID_Jump) begin
      if_id_flush_s = 1'b1;
    end else begin
      pc_write_s    = 1'b1;
      if_id_write_s = 1'b1;
    end
    // only branch and jump drive IF/ID flush, so it marks exactly the counted flush events
    flush_evt_s = if_id_flush_s;
  end

  // Next state and wait-counter value
  always_comb begin
    state_s    = state_r;
    wait_nxt_s = wait_cnt_r;
    case (state_r)
      RUN: begin
        if (hz.MEM_MemAccess && !hz.mem_ready) begin
          state_s    = MEM_WAIT;
          wait_nxt_s = {WAIT_W{1'b0}};
        end else begin
          state_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_s = RUN;
        end else if (wait_cnt_r != WAIT_MAX) begin
          state_s    = MEM_WAIT;
          wait_nxt_s = wait_cnt_r + WAIT_W'(1);
        end else begin
          state_s = MEM_WAIT;
        end
      end
      default: begin
        state_s    = RUN;
        wait_nxt_s = {WAIT_W{1'b0}};
      end
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= RUN;
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_nxt_s;
    end
  end

  // Performance counters (wrap naturally) and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r   <= {CNT_W{1'b0}};
      flush_cnt_r   <= {CNT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      if (!pc_write_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (flush_evt_s) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
      if ((state_r == MEM_WAIT) && (wait_nxt_s == WAIT_MAX)) begin
        mem_timeout_r <= 1'b1;
      end
    end
  end

  assign hz.PC_Write      = pc_write_s;
  assign hz.IF_ID_Write   = if_id_write_s;
  assign hz.IF_ID_Flush   = if_id_flush_s;
  assign hz.ID_EX_Flush   = id_ex_flush_s;
  assign hz.EX_MEM_Hold   = ex_mem_hold_s;
  assign hz.MEM_WB_Bubble = mem_wb_bubble_s;
  assign hz.stall_cnt     = stall_cnt_r;
  assign hz.flush_cnt     = flush_cnt_r;
  assign hz.mem_timeout   = mem_timeout_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized and directed bench for hazard_stall_ctrl against a rule-level reference model.
module tb_hazard_stall_ctrl;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: "waiting" = previous cycle was a memory stall
  bit               m_wait;
  int               m_mw;
  bit               m_to;
  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_flush;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int rs, input int rt, input bit use_rt, input bit jmp,
                       input int ex_rt, input bit mem_rd, input bit br,
                       input bit acc, input bit rdy);
    hz.ID_rs          = 5'(rs);
    hz.ID_rt          = 5'(rt);
    hz.ID_UseRt       = use_rt;
    hz.ID_Jump        = jmp;
    hz.EX_rt          = 5'(ex_rt);
    hz.EX_MemRead     = mem_rd;
    hz.EX_BranchTaken = br;
    hz.MEM_MemAccess  = acc;
    hz.mem_ready      = rdy;
  endtask

  // One clock cycle: check controls mid-cycle, then registered state after the edge
  task automatic step(input string tag);
    bit         stall, lu;
    logic [5:0] exp, got;
    @(negedge clk);
    stall = m_wait ? !hz.mem_ready : (hz.MEM_MemAccess && !hz.mem_ready);
    lu = hz.EX_MemRead && (hz.EX_rt != 5'd0) &&
         ((hz.EX_rt == hz.ID_rs) || (hz.ID_UseRt && (hz.EX_rt == hz.ID_rt)));
    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Hold, MEM_WB_Bubble}
    if (stall)                  exp = 6'b000011;
    else if (hz.EX_BranchTaken) exp = 6'b111100;
    else if (lu)                exp = 6'b000100;
    else if (hz.ID_Jump)        exp = 6'b111000;
    else                        exp = 6'b110000;
    got = {hz.PC_Write, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Flush,
           hz.EX_MEM_Hold, hz.MEM_WB_Bubble};
    check_eq({tag, ".ctrl"}, 32'(got), 32'(exp));
    if (!exp[5]) m_stall = m_stall + 1'b1;
    if (exp[3])  m_flush = m_flush + 1'b1;
    if (stall) begin
      if (m_wait) begin
        if (m_mw < TIMEOUT) m_mw++;
        if (m_mw >= TIMEOUT) m_to = 1'b1;
      end else begin
        m_mw = 0;
      end
    end
    m_wait = stall;
    @(posedge clk);
    #1;
    check_eq({tag, ".stall_cnt"}, 32'(hz.stall_cnt), 32'(m_stall));
    check_eq({tag, ".flush_cnt"}, 32'(hz.flush_cnt), 32'(m_flush));
    check_eq({tag, ".timeout"}, 32'(hz.mem_timeout), 32'(m_to));
  endtask

  // Asynchronous reset mid-cycle; idle inputs keep a non-reset MEM_WAIT visible as a stall
  task automatic do_reset();
    @(negedge clk);
    #2;
    drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_eq("rst.stall_cnt", 32'(hz.stall_cnt), 32'd0);
    check_eq("rst.flush_cnt", 32'(hz.flush_cnt), 32'd0);
    check_eq("rst.timeout", 32'(hz.mem_timeout), 32'd0);
    check_eq("rst.pc_write", 32'(hz.PC_Write), 32'd1);
    m_wait  = 1'b0;
    m_mw    = 0;
    m_to    = 1'b0;
    m_stall = '0;
    m_flush = '0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // load-use on rs, then the bubble clears it
    drive(5, 9, 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b1); step("lu_rs");
    check_eq("lu_rs.stall_is_1", 32'(hz.stall_cnt), 32'd1);
    drive(5, 9, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1); step("lu_clear");
    // r0 never hazards
    drive(0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1); step("lu_r0");
    // rt match only counts when rt is read
    drive(3, 7, 1'b1, 1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b1); step("lu_rt");
    drive(3, 7, 1'b0, 1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b1); step("lu_rt_unused");
    // branch overrides load-use
    drive(5, 5, 1'b1, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b1); step("lu_br");
    drive(1, 2, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1); step("jmp");
    drive(4, 2, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b1); step("jmp_lu");

    // 3-cycle memory stall with a pending branch; flush lands in the release cycle
    drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0); step("mem0");
    drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0); step("mem1");
    step("mem2");
    drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1); step("mem_rel");
    drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0); step("after_rel");

    // timeout boundary and stickiness
    do_reset();
    drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0); step("to_entry");
    drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) step("to_wait");
    check_eq("to_not_yet", 32'(hz.mem_timeout), 32'd0);
    step("to_last");
    check_eq("to_set", 32'(hz.mem_timeout), 32'd1);
    step("to_sat");
    drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1); step("to_rel");
    step("to_sticky");
    do_reset();

    // reset in the middle of a wait returns to RUN
    drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0); step("abort0");
    drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0); step("abort1");
    do_reset();
    step("abort_run");

    // randomized traffic, small register range to provoke matches
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
